// File: rtl/usb_pkg.sv
// usb_pkg: shared PID constants, PID class enum and capture FSM state enum.
package usb_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    typedef enum logic [1:0] {CLS_TOKEN, CLS_DATA, CLS_HANDSHAKE, CLS_INVALID} pid_class_t;

    typedef enum logic [1:0] {IDLE, PID, BODY, DISCARD} capture_state_t;

endpackage

// File: rtl/usb_pid_decode.sv
// usb_pid_decode: classifies a candidate PID byte; anything failing the nibble check or not supported is CLS_INVALID.
module usb_pid_decode
    import usb_pkg::*;
(
    input  logic [7:0] pid,
    output pid_class_t cls
);

    logic nib_ok;

    assign nib_ok = pid[7:4] == ~pid[3:0];

    // Table lookup gated by the complement check
    always_comb begin
        cls = CLS_INVALID;
        if (nib_ok) begin
            case (pid)
                PID_OUT, PID_IN, PID_SETUP:   cls = CLS_TOKEN;
                PID_DATA0, PID_DATA1:         cls = CLS_DATA;
                PID_ACK, PID_NAK, PID_STALL:  cls = CLS_HANDSHAKE;
                default:                      cls = CLS_INVALID;
            endcase
        end
    end

endmodule

// File: rtl/usb_pid_capture.sv
// usb_pid_capture: validates received USB packets and writes the PID of each well-formed one into the PID FIFO.
// Optional drop statistics counter enabled by defining PID_CAPTURE_STATS_EN.
module usb_pid_capture
    import usb_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64,
    parameter int CNT_W          = $clog2(MAX_DATA_BYTES + 3)
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        rcv_start,
    input  logic        rcv_byte_valid,
    input  logic [7:0]  rcv_data,
    input  logic        rcv_eop,
    input  logic        rcv_error,
    input  logic        fifo_full,
    output logic        fifo_w_enable,
    output logic [7:0]  fifo_w_data,
    output logic        pid_err,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    capture_state_t   state;
    pid_class_t       cls;
    pid_class_t       dec_cls;
    logic [7:0]       pid_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   cls_min;
    logic [CNT_W:0]   cls_max;

    usb_pid_decode u_decode (
        .pid (rcv_data),
        .cls (dec_cls)
    );

    assign cnt_inc = {1'b0, cnt} + 1'b1;

    // Body length window for the latched PID class
    always_comb begin
        cls_max = cls == CLS_DATA  ? (CNT_W+1)'(MAX_DATA_BYTES + 2) :
                  cls == CLS_TOKEN ? (CNT_W+1)'(2) : '0;
        cls_min = cls == CLS_HANDSHAKE ? '0 : (CNT_W+1)'(2);
    end

    // Capture FSM; events resolved as start > error > eop > byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cls           <= CLS_INVALID;
            pid_q         <= '0;
            cnt           <= '0;
            fifo_w_enable <= 1'b0;
            fifo_w_data   <= '0;
            pid_err       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            fifo_w_enable <= 1'b0;
            pid_err       <= 1'b0;
            overflow      <= 1'b0;
            case (state)
                IDLE: begin
                    if (rcv_start) state <= PID;
                end
                PID: begin
                    if (rcv_start) begin
                        pid_err <= 1'b1;
                    end else if (rcv_error) begin
                        pid_err <= 1'b1;
                        state   <= DISCARD;
                    end else if (rcv_eop) begin
                        pid_err <= 1'b1;
                        state   <= IDLE;
                    end else if (rcv_byte_valid) begin
                        if (dec_cls != CLS_INVALID) begin
                            pid_q <= rcv_data;
                            cls   <= dec_cls;
                            cnt   <= '0;
                            state <= BODY;
                        end else begin
                            pid_err <= 1'b1;
                            state   <= DISCARD;
                        end
                    end
                end
                BODY: begin
                    if (rcv_start) begin
                        pid_err <= 1'b1;
                        state   <= PID;
                    end else if (rcv_error) begin
                        pid_err <= 1'b1;
                        state   <= DISCARD;
                    end else if (rcv_eop) begin
                        state <= IDLE;
                        if ({1'b0, cnt} >= cls_min) begin
                            if (fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                fifo_w_enable <= 1'b1;
                                fifo_w_data   <= pid_q;
                            end
                        end else begin
                            pid_err <= 1'b1;
                        end
                    end else if (rcv_byte_valid) begin
                        if (cnt_inc > cls_max) begin
                            pid_err <= 1'b1;
                            state   <= DISCARD;
                        end else begin
                            cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                DISCARD: begin
                    if (rcv_start) state <= PID;
                    else if (rcv_eop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PID_CAPTURE_STATS_EN
    // Saturating count of every rejected or overflowed packet
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) drop_cnt <= '0;
        else if ((pid_err || overflow) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule
